// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port dmem arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int         NUM_PORTS  = 2;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant picker for the dmem arbiter: fixed priority by default, or
// round-robin with a last-grant pointer when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic                 clk,
  input  logic                 reset_n,
`endif
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] valid,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef DMEM_ARB_RR_EN
  // Port that won the most recent grant; resets to 1 so port 0 wins first.
  port_id_t last_reg;

  always_comb begin
    grant = '0;
    if (en) begin
      if (&valid) grant = last_reg ? 2'b01 : 2'b10;
      else        grant = valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_reg <= 1'b1;
    else if (|grant) last_reg <= grant[1];
  end
`else
  always_comb begin
    grant = '0;
    if (en) grant = {valid[1] & ~valid[0], valid[0]};
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a combinational-read dmem.
// Arbitration policy is selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp0_err,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          rsp1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  arb_state_t           state_reg;
  port_id_t             port_reg;
  logic                 err_reg;
  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] grant;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;
  logic                 sel_misaligned;

  assign req_valid  = {req1_valid, req0_valid};
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .en      (state_reg == IDLE),
    .valid   (req_valid),
    .grant   (grant)
  );

  always_comb begin
    sel_we    = grant[1] ? req1_we    : req0_we;
    sel_addr  = grant[1] ? req1_addr  : req0_addr;
    sel_wdata = grant[1] ? req1_wdata : req0_wdata;
    sel_misaligned = |(sel_addr[1:0] & ALIGN_MASK);
  end

  // mem_a/mem_wd double as the request latch; mem_we is pre-computed at grant
  // time so it is a clean registered strobe during ACCESS only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      port_reg  <= 1'b0;
      err_reg   <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_wd    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            port_reg  <= grant[1];
            err_reg   <= sel_misaligned;
            mem_we    <= sel_we & ~sel_misaligned;
            mem_a     <= sel_addr;
            mem_wd    <= sel_wdata;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
      logic          valid_reg;
      logic          err_q_reg;
      logic [DW-1:0] rdata_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          err_q_reg <= 1'b0;
          rdata_reg <= '0;
        end else begin
          valid_reg <= 1'b0;
          if (state_reg == ACCESS && port_reg == port_id_t'(gi)) begin
            valid_reg <= 1'b1;
            err_q_reg <= err_reg;
            rdata_reg <= err_reg ? '0 : mem_rd;
          end
        end
      end
    end
  endgenerate

  assign rsp0_valid = g_rsp[0].valid_reg;
  assign rsp0_err   = g_rsp[0].err_q_reg;
  assign rsp0_rdata = g_rsp[0].rdata_reg;
  assign rsp1_valid = g_rsp[1].valid_reg;
  assign rsp1_err   = g_rsp[1].err_q_reg;
  assign rsp1_rdata = g_rsp[1].rdata_reg;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-clock `dmem` (combinational read, write on rising `clk`). It lets the core load/store path (port 0) and a debug/DMA loader (port 1) share the one data memory through valid/ready handshakes. It serialises accesses, registers the read data into per-port response slots, and rejects misaligned word accesses without touching memory.

## Interface
- `AW`, 32: address width, must match `dmem.a`.
- `DW`, 32: data width, must match `dmem.wd`/`dmem.rd`.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req0_valid` in 1: port 0 request present.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_we` in 1: 1 = write, 0 = read.
- `req0_addr` in AW: byte address.
- `req0_wdata` in DW: write data.
- `rsp0_valid` out 1: one-cycle response pulse.
- `rsp0_rdata` out DW: read data (write: pre-write contents).
- `rsp0_err` out 1: misaligned-address error, qualified by `rsp0_valid`.
- `req1_*` / `rsp1_*`: identical set for port 1.
- `mem_we` out 1: to `dmem.we`.
- `mem_a` out AW: to `dmem.a`.
- `mem_wd` out DW: to `dmem.wd`.
- `mem_rd` in DW: from `dmem.rd`.

## Operation
- FSM states: IDLE and ACCESS.
- IDLE: if any `reqN_valid`, choose the winner, assert `reqN_ready` combinationally for the winner only, latch we/addr/wdata/port-id, and go to ACCESS. With no request, stay in IDLE.
- ACCESS: drive `mem_a` and `mem_wd` from the latched values. Drive `mem_we` = latched we AND aligned. At the closing edge, capture `mem_rd` into the winner's response register and set that port's `rsp_valid`. Return to IDLE unconditionally.
- `rspN_valid` is high for exactly the one cycle after ACCESS. It may coincide with a new IDLE grant, including to the same port.
- Misaligned (`addr[1:0] != 0`): `mem_we` stays 0. Response has `rsp_err`=1 and `rsp_rdata`=0.
- Arbitration: fixed priority, or round-robin (see Configuration). A lone requester is always granted.
- `mem_we` is 0 in every cycle except an aligned write ACCESS. `mem_a`/`mem_wd` hold the last latched values in IDLE.
- Requesters hold their request stable until `ready`. The arbiter never drops an accepted request.

## Timing
- Latency: request accepted in cycle T, memory access in T+1, `rsp_valid` in T+2.
- Throughput: one access per 2 cycles. Back-to-back grants are accepted at T, T+2, T+4, …
- Write data lands in `dmem` at the rising edge ending the ACCESS cycle.
- Reset values: all `ready` 0, all `rsp_valid` 0, all `rsp_rdata` 0, all `rsp_err` 0, `mem_we` 0, `mem_a` 0, `mem_wd` 0, state IDLE, round-robin pointer = port 1 (so port 0 wins first).
- Reset asserted during ACCESS: `mem_we` drops immediately (asynchronously), no write occurs, and the in-flight response is discarded.
- Both ports valid in the same IDLE cycle: exactly one `ready`. The loser keeps its request and is granted in the next IDLE cycle at the earliest.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On contention, grant the port not granted last; the pointer updates on every grant. Worst-case wait for either port is 2 grants.
- Undefined: fixed priority. Port 0 always wins contention, and port 1 can starve. The pointer register is not built.

## Structure
- Package `dmem_arb_pkg`:
  - `arb_state_t` enum (IDLE, ACCESS)
  - `port_id_t` (1 bit)
  - `ALIGN_MASK` = 2'b11
  - `NUM_PORTS` = 2
- Sub-module `dmem_arb_pick`: combinational grant picker plus the round-robin pointer flop. It takes the two valids and returns a one-hot grant. The `DMEM_ARB_RR_EN` variation is confined here.
- Top level holds the FSM, the request latch, and the per-port response registers.

## Test plan
- Reset release, port 0 write addr 0x14, data 0xA5A5A5A5 -> `req0_ready` at T, `mem_we`=1 only at T+1, `rsp0_valid` at T+2. A later port 0 read of 0x14 returns 0xA5A5A5A5.
- Both ports read at once, with RR_EN -> port 0 granted first, then port 1 at T+2. Holding both valid for 4 grants -> order 0,1,0,1. Without RR_EN -> order 0,0,0,0.
- Port 1 write to misaligned addr 0x16 -> `mem_we` never 1, `rsp1_err`=1, `rsp1_rdata`=0. Memory word 0x14 is unchanged.
- Write-then-read same address, back to back from port 1 -> second response returns new data. The first write's `rsp1_rdata` returns the old contents.
- `reset_n` low mid-ACCESS of a write of 0xDEADBEEF to 0x20 -> `mem_we` 0 within the cycle, no `rsp_valid`, and a read of 0x20 after reset returns the prior value.
- Idle bus for 10 cycles -> `mem_we`=0, no `ready`, and no `rsp_valid` on either port.
